instruction_encoder: RTL

- Streaming RV32I instruction encoder; the inverse of the datapath immediate generator.
- Accepts a decoded instruction description (format, opcode, register fields, funct fields, 32-bit signed immediate) over a valid/ready handshake.
- Checks the immediate for range and alignment, packs it into the format-specific bit positions, and emits the 32-bit word with its target byte address over a second valid/ready handshake.
- Used by the instruction-memory loader and as a golden source for datapath benches.

---
 rtl/instruction_encoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// Streaming RV32I instruction encoder: packs a decoded instruction description into a
// 32-bit word, validating the immediate, and emits it with its byte address.
module instruction_encoder #(
    parameter int          INSTRUCTION_SIZE = 32,
    parameter int          IMMEDIATE_SIZE   = 32,
    parameter int          ADDR_WIDTH       = 12,
    parameter int unsigned BASE_ADDR        = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Flush,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [2:0]                  Format,
    input  logic [6:0]                  Opcode,
    input  logic [4:0]                  Rd,
    input  logic [4:0]                  Rs1,
    input  logic [4:0]                  Rs2,
    input  logic [2:0]                  Funct3,
    input  logic [6:0]                  Funct7,
    input  logic [IMMEDIATE_SIZE-1:0]   Immediate,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [INSTRUCTION_SIZE-1:0] InstructionOut,
    output logic [ADDR_WIDTH-1:0]       AddressOut,
    output logic                        ErrorFlag,
    output logic [1:0]                  ErrorCode,
    output logic [15:0]                 EmitCount
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } format_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_RANGE  = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_FORMAT = 2'd3
    } error_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

    logic signed [IMMEDIATE_SIZE-1:0]   imm;
    logic [INSTRUCTION_SIZE-1:0]        word;
    logic                               range_bad;
    logic                               align_bad;
    error_t                             err;
    logic [ADDR_WIDTH-1:0]              addr_q;
    logic                               accept;
    logic                               transfer;

    assign imm      = Immediate;
    assign InReady  = !Flush && (!OutValid || OutReady);
    assign accept   = InValid && InReady;
    assign transfer = OutValid && OutReady;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        word      = '0;
        range_bad = 1'b0;
        align_bad = 1'b0;
        err       = ERR_NONE;
        case (Format)
            FMT_R: word = {Funct7, Rs2, Rs1, Funct3, Rd, Opcode};
            FMT_I: begin
                word      = {imm[11:0], Rs1, Funct3, Rd, Opcode};
                range_bad = (imm < -2048) || (imm > 2047);
            end
            FMT_S: begin
                word      = {imm[11:5], Rs2, Rs1, Funct3, imm[4:0], Opcode};
                range_bad = (imm < -2048) || (imm > 2047);
            end
            FMT_B: begin
                word      = {imm[12], imm[10:5], Rs2, Rs1, Funct3, imm[4:1], imm[11], Opcode};
                range_bad = (imm < -4096) || (imm > 4095);
                align_bad = imm[0];
            end
            FMT_U: begin
                word      = {imm[31:12], Rd, Opcode};
                align_bad = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], Rd, Opcode};
                range_bad = (imm < -1048576) || (imm > 1048575);
                align_bad = imm[0];
            end
            default: err = ERR_FORMAT;
        endcase
        // Illegal format outranks range, which outranks alignment.
        if (err == ERR_NONE) begin
            if (range_bad)      err = ERR_RANGE;
            else if (align_bad) err = ERR_ALIGN;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OutValid       <= 1'b0;
            InstructionOut <= '0;
            AddressOut     <= BASE;
            addr_q         <= BASE;
            ErrorFlag      <= 1'b0;
            ErrorCode      <= ERR_NONE;
            EmitCount      <= '0;
        end else if (Flush) begin
            OutValid   <= 1'b0;
            AddressOut <= BASE;
            addr_q     <= BASE;
            ErrorFlag  <= 1'b0;
            ErrorCode  <= ERR_NONE;
            EmitCount  <= '0;
        end else begin
            if (transfer && (EmitCount != 16'hFFFF)) begin
                EmitCount <= EmitCount + 16'd1;
            end
            if (accept && (err == ERR_NONE)) begin
                OutValid       <= 1'b1;
                InstructionOut <= word;
                AddressOut     <= addr_q;
                addr_q         <= addr_q + ADDR_WIDTH'(4);
            end else if (transfer) begin
                OutValid <= 1'b0;
            end
            // Erroneous requests are consumed silently; only the first code since clear is kept.
            if (accept && (err != ERR_NONE)) begin
                ErrorFlag <= 1'b1;
                if (!ErrorFlag) begin
                    ErrorCode <= err;
                end
            end
        end
    end

endmodule
